// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, instruction-memory waits and operand forwarding selects.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              cond_stage,
    input  logic              imem_ready,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        FLUSH   = 2'b10,
        IMWAIT  = 2'b11
    } state_t;

    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0]       LD_INIT    = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       lu;

    assign state = state_q;

    assign lu = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    // EX result wins over MEM result; loads cannot forward from EX.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (ex_reg_write && !ex_is_load && (ex_rd != '0) && (ex_rd == rs))
            return 2'b01;
        else if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;

        if (!reset) begin
            fwd_a = fwd_sel(id_rs1);
            fwd_b = fwd_sel(id_rs2);

            if (cond_stage) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    state_d = RUN;
                end
            end else begin
                unique case (state_q)
                    FLUSH: begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (cnt_q == 3'd1) state_d = RUN;
                        else               cnt_d   = cnt_q - 3'd1;
                    end
                    LDSTALL: begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (cnt_q == 3'd1) state_d = RUN;
                        else               cnt_d   = cnt_q - 3'd1;
                    end
                    default: begin
                        if (lu) begin
                            pc_hold      = 1'b1;
                            if_id_hold   = 1'b1;
                            id_ex_bubble = 1'b1;
                            if (LOAD_BUBBLES > 1) begin
                                state_d = LDSTALL;
                                cnt_d   = LD_INIT;
                            end else begin
                                state_d = RUN;
                            end
                        end else if (!imem_ready) begin
                            pc_hold     = 1'b1;
                            if_id_flush = 1'b1;
                            state_d     = IMWAIT;
                        end else begin
                            state_d = RUN;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_hold && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a counting model of remaining flush/stall cycles.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int LB     = 2;
    localparam int FC     = 2;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk1 = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic              id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load;
    logic              mem_reg_write, cond_stage, imem_ready;
    logic              pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
    logic [1:0]        fwd_a, fwd_b, state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    always #5 clk1 = ~clk1;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .LOAD_BUBBLES(LB), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .clk1(clk1), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .cond_stage(cond_stage), .imem_ready(imem_ready),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic              rst, cond, ready, use1, use2, exw, exl, memw;
        logic [REG_AW-1:0] rs1, rs2, exrd, memrd;
    } stim_t;

    typedef struct {
        logic             ph, ih, fl, bb;
        logic [1:0]       fa, fb, st;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: cycles of flush/stall still owed after the current one.
    int m_flush = 0, m_stall = 0, m_sc = 0, m_fc = 0;
    bit m_imwait = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input stim_t s, input logic [REG_AW-1:0] rs);
        if (s.exw && !s.exl && s.exrd != 0 && s.exrd == rs) return 2'b01;
        if (s.memw && s.memrd != 0 && s.memrd == rs)        return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   lu;
        @(posedge clk1);
        #1;
        reset = s.rst;  cond_stage = s.cond;  imem_ready = s.ready;
        id_use_rs1 = s.use1;  id_use_rs2 = s.use2;
        ex_reg_write = s.exw;  ex_is_load = s.exl;  mem_reg_write = s.memw;
        id_rs1 = s.rs1;  id_rs2 = s.rs2;  ex_rd = s.exrd;  mem_rd = s.memrd;

        e = '{ph: 0, ih: 0, fl: 0, bb: 0, fa: 0, fb: 0, st: 0, sc: 0, fc: 0};
        e.st = (m_flush > 0) ? 2'b10 : (m_stall > 0) ? 2'b01 : m_imwait ? 2'b11 : 2'b00;
        e.sc = CNT_W'(m_sc);
        e.fc = CNT_W'(m_fc);

        if (s.rst) begin
            m_flush = 0; m_stall = 0; m_imwait = 0; m_sc = 0; m_fc = 0;
        end else begin
            lu = s.exl && s.exw && s.exrd != 0 &&
                 ((s.use1 && s.rs1 == s.exrd) || (s.use2 && s.rs2 == s.exrd));
            e.fa = model_fwd(s, s.rs1);
            e.fb = model_fwd(s, s.rs2);
            if (s.cond) begin
                e.fl = 1; e.bb = 1;
                m_flush = FC - 1; m_stall = 0; m_imwait = 0;
            end else if (m_flush > 0) begin
                e.fl = 1; e.bb = 1;
                m_flush--;
            end else if (m_stall > 0) begin
                e.ph = 1; e.ih = 1; e.bb = 1;
                m_stall--;
            end else if (lu) begin
                e.ph = 1; e.ih = 1; e.bb = 1;
                m_stall = LB - 1; m_imwait = 0;
            end else if (!s.ready) begin
                e.ph = 1; e.fl = 1;
                m_imwait = 1;
            end else begin
                m_imwait = 0;
            end
            if (e.ph) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
            if (e.fl) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
        end
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_hold",      16'(pc_hold),      16'(e.ph));
                check("if_id_hold",   16'(if_id_hold),   16'(e.ih));
                check("if_id_flush",  16'(if_id_flush),  16'(e.fl));
                check("id_ex_bubble", 16'(id_ex_bubble), 16'(e.bb));
                check("fwd_a",        16'(fwd_a),        16'(e.fa));
                check("fwd_b",        16'(fwd_b),        16'(e.fb));
                check("state",        16'(state),        16'(e.st));
                check("stall_cnt",    16'(stall_cnt),    16'(e.sc));
                check("flush_cnt",    16'(flush_cnt),    16'(e.fc));
                check("hold_and_flush", 16'(if_id_hold & if_id_flush), 16'(0));
            end
        end
    end

    initial begin : stimulus
        stim_t idle, s;
        idle = '{rst: 0, cond: 0, ready: 1, use1: 0, use2: 0, exw: 0, exl: 0, memw: 0,
                 rs1: 0, rs2: 0, exrd: 0, memrd: 0};
        reset = 1; cond_stage = 0; imem_ready = 1; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_reg_write = 0; ex_is_load = 0; mem_reg_write = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
        @(posedge clk1);

        // reset held with a branch pending, then release
        s = idle; s.rst = 1; s.cond = 1;
        apply(s); apply(s);
        apply(idle);
        // load-use on rs2, then the same with rd = x0
        s = idle; s.exl = 1; s.exw = 1; s.exrd = 5; s.rs2 = 5; s.use2 = 1;
        apply(s); apply(idle); apply(idle);
        s.exrd = 0; s.rs2 = 0;
        apply(s); apply(idle);
        // single branch, then a second branch inside the flush window
        s = idle; s.cond = 1;
        apply(s); apply(idle); apply(idle);
        apply(s); apply(idle); apply(s); apply(idle); apply(idle);
        // branch beats load-use and imem wait together
        s = idle; s.cond = 1; s.ready = 0; s.exl = 1; s.exw = 1; s.exrd = 3;
        s.rs1 = 3; s.use1 = 1;
        apply(s); apply(idle); apply(idle);
        // imem wait for 3 cycles
        s = idle; s.ready = 0;
        repeat (3) apply(s);
        apply(idle);
        // forwarding priority
        s = idle; s.exrd = 7; s.memrd = 7; s.rs1 = 7; s.rs2 = 7; s.exw = 1; s.memw = 1;
        apply(s);
        s.exw = 0;   apply(s);
        s.memrd = 0; apply(s);
        // long imem wait drives stall_cnt into saturation
        s = idle; s.ready = 0;
        repeat (20) apply(s);
        apply(idle);

        repeat (3000) begin
            s.rst   = ($urandom_range(0, 59) == 0);
            s.cond  = ($urandom_range(0, 9) == 0);
            s.ready = ($urandom_range(0, 5) != 0);
            s.use1  = 1'($urandom);  s.use2 = 1'($urandom);
            s.exw   = 1'($urandom);  s.exl  = 1'($urandom);  s.memw = 1'($urandom);
            s.rs1   = REG_AW'($urandom_range(0, 3));
            s.rs2   = REG_AW'($urandom_range(0, 3));
            s.exrd  = REG_AW'($urandom_range(0, 3));
            s.memrd = REG_AW'($urandom_range(0, 3));
            apply(s);
        end

        @(negedge clk1);
        @(negedge clk1);
        #1;
        check("scoreboard_drained", 16'(sb.size()), 16'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It watches the register addresses in ID, EX and MEM, the branch-resolve strobe cond_stage and instruction-memory readiness. From these it drives the PC-hold, IF/ID-hold, IF/ID-flush and ID/EX-bubble controls, plus the operand-forwarding selects. Sits beside IF_ID and ID_EX; purely a control block, no datapath storage except counters.

Parameters:
REG_AW, 5, register-address width
LOAD_BUBBLES, 1, hold cycles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 2, flush cycles per taken branch (1..7)
CNT_W, 16, width of statistics counters

Ports:
clk1  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
id_rs1  in  REG_AW  ID-stage source reg 1
id_rs2  in  REG_AW  ID-stage source reg 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  EX-stage destination
ex_reg_write  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
mem_rd  in  REG_AW  MEM-stage destination
mem_reg_write  in  1  MEM instruction writes rd
cond_stage  in  1  branch/jump taken, resolved this cycle
imem_ready  in  1  instruction memory data valid this cycle
pc_hold  out  1  PC keeps value
if_id_hold  out  1  IF/ID keeps contents
if_id_flush  out  1  IF/ID loads NOP (0x00000013)
id_ex_bubble  out  1  ID/EX loads NOP/control-zero
fwd_a  out  2  rs1 operand source: 00 regfile, 01 EX result, 10 MEM result
fwd_b  out  2  rs2 operand source, same encoding
state  out  2  FSM state
stall_cnt  out  CNT_W  cycles with pc_hold=1
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- States: RUN=00, LDSTALL=01, FLUSH=10, IMWAIT=11. Internal down-counter cnt (3 bits).
- Reset (reset=1 at edge): state<=RUN, cnt<=0, stall_cnt<=0, flush_cnt<=0. While reset=1, all control outputs and fwd_* are 0. Reset mid-sequence aborts it; next cycle is RUN.
- Control outputs are combinational from state and current inputs. State, cnt and counters are registered.
- Load-use hazard lu = ex_is_load & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in every state: cond_stage > in-progress LDSTALL/FLUSH > lu > !imem_ready.
- cond_stage=1 (any state):
  - Outputs: if_id_flush=1, id_ex_bubble=1, pc_hold=0, if_id_hold=0.
  - If FLUSH_CYCLES>1: next FLUSH, cnt<=FLUSH_CYCLES-1. Otherwise next RUN.
  - cond_stage during FLUSH restarts cnt.
- FLUSH: if_id_flush=1, id_ex_bubble=1. cnt decrements; when cnt==1, next RUN. Total flush cycles = FLUSH_CYCLES.
- RUN with lu=1:
  - Outputs: pc_hold=1, if_id_hold=1, id_ex_bubble=1.
  - If LOAD_BUBBLES>1: next LDSTALL, cnt<=LOAD_BUBBLES-1. Otherwise stay RUN.
- LDSTALL: pc_hold=1, if_id_hold=1, id_ex_bubble=1. cnt decrements; when cnt==1, next RUN. Total hold cycles = LOAD_BUBBLES.
- RUN/IMWAIT with imem_ready=0 and no higher-priority event:
  - Outputs: pc_hold=1, if_id_flush=1. ID/EX advances normally.
  - Next IMWAIT. IMWAIT→RUN on the cycle imem_ready=1, with normal outputs that cycle.
- if_id_hold and if_id_flush are never both 1.
- Forwarding (all states):
  - fwd_a=01 if ex_reg_write & !ex_is_load & ex_rd!=0 & ex_rd==id_rs1.
  - Else fwd_a=10 if mem_reg_write & mem_rd!=0 & mem_rd==id_rs1.
  - Else fwd_a=00.
  - fwd_b: same rule using id_rs2. EX match wins over MEM match.
- Counters: increment at the edge when the respective output is 1; saturate at all-ones; no wrap.

Test Plan:
- Reset: reset=1 for 2 cycles with cond_stage=1 → all outputs 0, state=00, counters 0; release → RUN, no flush.
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1, LOAD_BUBBLES=2 → pc_hold/if_id_hold/id_ex_bubble high exactly 2 cycles, state 00→01→00, stall_cnt=2. Same stimulus with ex_rd=0 → no stall.
- Branch: one-cycle cond_stage=1, FLUSH_CYCLES=2 → if_id_flush=id_ex_bubble=1 for 2 cycles, pc_hold=0, flush_cnt=2. Second cond_stage in FLUSH → 2 further cycles from that point.
- Priority: cond_stage=1 together with lu=1 and imem_ready=0 → flush outputs only, pc_hold=0, next state FLUSH.
- Imem wait: imem_ready=0 for 3 cycles → pc_hold=if_id_flush=1 for 3 cycles, state 11, stall_cnt=3; imem_ready=1 → RUN, outputs 0.
- Forwarding: ex_rd=mem_rd=7, id_rs1=7, both writes=1, ex_is_load=0 → fwd_a=01. ex_reg_write=0 → 10. mem_rd=0 → 00. Counter saturation with CNT_W=2: 5 stall cycles → stall_cnt=3.
